simon_cipher_collector: RTL and testbench
=========================================

Name: simon_cipher_collector

Overview:
Downstream stage of the bit-serial Simon 128/128 core. Captures the serial ciphertext bit stream (one bit per clock while the core's valid is high) into a 128-bit block register. Then drains the block as 16 bytes over a valid/ready byte interface toward the chip I/O.
Decouples the core's fixed-rate serial output from a slower, back-pressured byte consumer. Flags any ciphertext lost while a drain is in progress.

Parameters:
BLOCK_BITS, 128, ciphertext block width in bits; must be a multiple of BYTE_W.
BYTE_W, 8, output byte width.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
cipher_in  input  1  serial ciphertext bit from the core's cipher_out
valid_in  input  1  core's valid; cipher_in is sampled on every clock where this is 1
clear  input  1  synchronous abort/flush, active-high
byte_out  output  BYTE_W  current output byte
byte_valid  output  1  byte_out holds a valid byte
byte_ready  input  1  consumer accepts byte_out when byte_valid && byte_ready
block_done  output  1  one-cycle pulse after the last byte of a block is accepted
overrun  output  1  sticky; set when valid_in=1 arrives during DRAIN
busy  output  1  1 when bit_cnt != 0 or state == DRAIN

Behaviour:
- Reset (reset=0, asynchronous):
  - state=COLLECT; bit_cnt=0; byte_cnt=0; shift register=0.
  - byte_valid=0, block_done=0, overrun=0, byte_out=0, busy=0.
- Registers:
  - 128-bit shift register sr.
  - bit_cnt, clog2(BLOCK_BITS) bits, range 0..127.
  - byte_cnt, clog2(BLOCK_BITS/BYTE_W) bits, range 0..15.
- State COLLECT:
  - On each clock with valid_in=1: sr <= {cipher_in, sr[127:1]}; bit_cnt++.
  - The first received bit ends up at sr[0], i.e. LSB-first block order.
  - valid_in=0 gaps: sr and bit_cnt hold; bits already collected are retained.
  - When the capture makes bit_cnt reach 127 -> 128, bit_cnt wraps to 0 and the state goes to DRAIN.
  - byte_valid goes to 1 from the next cycle onward. Latency from the last serial bit edge to byte_valid is 1 cycle.
- State DRAIN:
  - byte_valid=1 and byte_out=sr[BYTE_W-1:0], both registered and stable while byte_ready=0.
  - On byte_valid && byte_ready: sr shifts right by BYTE_W; byte_cnt++.
  - byte 0 = sr[7:0] is the first byte out (the first 8 serial bits, first bit at the LSB).
  - On acceptance of byte 15:
    - byte_cnt wraps to 0 and the state goes to COLLECT.
    - byte_valid drops the next cycle.
    - block_done=1 for exactly that next cycle.
  - valid_in=1 during DRAIN: the bit is discarded, sr is untouched, and overrun<=1 (sticky).
  - On the cycle of the final accept, the state is still DRAIN, so valid_in=1 there also counts as overrun. The new block may start capturing the following cycle.
- clear=1 (highest priority after reset):
  - Next state COLLECT; bit_cnt=0, byte_cnt=0, sr=0.
  - byte_valid=0, overrun=0, block_done=0.
  - The input bit on that cycle is ignored.
- Reset or clear mid-collect or mid-drain: the partial block is lost, with no block_done pulse.
- No combinational path from any input to any output.
- Consecutive blocks: a back-to-back consumer (byte_ready tied to 1) drains in 16 cycles.

Decomposition:
- Shared package simon_pkg holds:
  - SIMON_BLOCK_BITS=128, SIMON_WORD_BITS=64, SIMON_ROUNDS=68.
  - The collector state enum {COLLECT, DRAIN}.
- The collector is a single module with no sub-module. The 2-state FSM, counters and shift register are each small; splitting them adds ports without reuse.

Test Plan:
- Serial capture and LSB-first ordering:
  - Stimulus: reset, then 128 contiguous valid_in=1 cycles carrying 128'h00112233445566778899AABBCCDDEEFF LSB-first, with byte_ready=1.
  - Required: byte_valid rises 1 cycle after the last bit. Bytes out are FF,EE,DD,...,11,00 in 16 consecutive cycles. block_done pulses once. overrun=0.
- Gapped input:
  - Stimulus: same block, but valid_in toggles 1/0 every other cycle.
  - Required: identical byte sequence; busy=1 throughout the collect.
- Backpressure:
  - Stimulus: byte_ready low for 5 cycles before each byte.
  - Required: byte_out stays constant while stalled; 16 bytes in order; block_done only after byte 16 is accepted.
- Overrun:
  - Stimulus: hold byte_ready=0 during DRAIN and pulse valid_in=1 for 3 cycles.
  - Required: overrun=1 and stays 1. The drained bytes are unchanged. A subsequent clear=1 returns overrun to 0.
- clear mid-collect:
  - Stimulus: after 70 bits, assert clear for 1 cycle, then send a full new block 128'hFFFF...FF00.
  - Required: output bytes are 00 followed by 15 x FF; exactly one block_done pulse.
- Async reset mid-drain:
  - Stimulus: drop reset for 1 cycle (asynchronously, between clock edges) after 4 bytes have been drained.
  - Required: byte_valid=0 immediately; all counters are 0. The next full 128-bit stream drains correctly from byte 0.

Source files
------------

// File: rtl/simon_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// simon_pkg : shared Simon 128/128 constants and collector state encoding
// Revision  : 1.0
// ---------------------------------------------------------------------------
package simon_pkg;

  localparam int SIMON_BLOCK_BITS = 128;
  localparam int SIMON_WORD_BITS  = 64;
  localparam int SIMON_ROUNDS     = 68;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    DRAIN   = 1'b1
  } collector_state_e;

endpackage
`default_nettype wire

// File: rtl/simon_cipher_collector.sv
`default_nettype none
// ---------------------------------------------------------------------------
// simon_cipher_collector : serial ciphertext capture, drained as bytes (valid/ready)
// Revision               : 1.0
// ---------------------------------------------------------------------------
module simon_cipher_collector
  import simon_pkg::*;
#(
  parameter int BLOCK_BITS = SIMON_BLOCK_BITS,
  parameter int BYTE_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cipher_in,
  input  logic              valid_in,
  input  logic              clear,
  output logic [BYTE_W-1:0] byte_out,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              block_done,
  output logic              overrun,
  output logic              busy
);

  localparam int NUM_BYTES  = BLOCK_BITS / BYTE_W;
  localparam int BIT_CNT_W  = $clog2(BLOCK_BITS);
  localparam int BYTE_CNT_W = $clog2(NUM_BYTES);
  localparam logic [BIT_CNT_W-1:0]  LAST_BIT  = BIT_CNT_W'(BLOCK_BITS - 1);
  localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(NUM_BYTES - 1);

  collector_state_e        state, state_next;
  logic [BLOCK_BITS-1:0]   sr;
  logic [BIT_CNT_W-1:0]    bit_cnt;
  logic [BYTE_CNT_W-1:0]   byte_cnt;
  logic                    capture;
  logic                    accept;

  assign capture = (state == COLLECT) && valid_in;
  assign accept  = (state == DRAIN) && byte_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= COLLECT;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = COLLECT;
    end else begin
      case (state)
        COLLECT: if (capture && bit_cnt == LAST_BIT) state_next = DRAIN;
        DRAIN:   if (accept && byte_cnt == LAST_BYTE) state_next = COLLECT;
        default: state_next = COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr         <= '0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      block_done <= 1'b0;
      overrun    <= 1'b0;
    end else if (clear) begin
      sr         <= '0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      block_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      block_done <= 1'b0;
      // New bits enter at the MSB so the first bit received lands at sr[0].
      if (capture) begin
        sr      <= {cipher_in, sr[BLOCK_BITS-1:1]};
        bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
      end
      if (accept) begin
        sr <= sr >> BYTE_W;
        if (byte_cnt == LAST_BYTE) begin
          byte_cnt   <= '0;
          block_done <= 1'b1;
        end else begin
          byte_cnt <= byte_cnt + 1'b1;
        end
      end
      if (state == DRAIN && valid_in) overrun <= 1'b1;
    end
  end

  // All outputs come straight from registers; no input reaches an output combinationally.
  assign byte_out   = sr[BYTE_W-1:0];
  assign byte_valid = (state == DRAIN);
  assign busy       = (bit_cnt != '0) || (state == DRAIN);

endmodule
`default_nettype wire

// File: tb/tb_simon_cipher_collector.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_simon_cipher_collector : directed scoreboard bench for the ciphertext collector
// Revision                  : 1.0
// ---------------------------------------------------------------------------
module tb_simon_cipher_collector;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cipher_in = 1'b0;
  logic       valid_in = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ready = 1'b0;
  logic       block_done;
  logic       overrun;
  logic       busy;

  int n_cmp  = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int done_base;
  logic [7:0] sb[$];

  simon_cipher_collector #(.BLOCK_BITS(128), .BYTE_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .cipher_in  (cipher_in),
    .valid_in   (valid_in),
    .clear      (clear),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .block_done (block_done),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (block_done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_block(input logic [127:0] blk, input bit gapped);
    for (int k = 0; k < 16; k++) sb.push_back(blk[8*k +: 8]);
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      if (i == 127) check("pre_latency_valid", {31'b0, byte_valid}, 32'd0);
      valid_in  = 1'b1;
      cipher_in = blk[i];
      if (gapped && i != 127) begin
        @(negedge clk);
        valid_in = 1'b0;
        check("gap_busy", {31'b0, busy}, 32'd1);
      end
    end
    @(negedge clk);
    valid_in = 1'b0;
    check("latency_valid", {31'b0, byte_valid}, 32'd1);
  endtask

  task automatic drain(input int stall, input int nbytes);
    logic [7:0] exp;
    for (int k = 0; k < nbytes; k++) begin
      if (sb.size() == 0) begin
        check("scoreboard_empty", 32'd0, 32'd1);
        exp = 8'h00;
      end else begin
        exp = sb.pop_front();
      end
      for (int s = 0; s < stall; s++) begin
        byte_ready = 1'b0;
        check("stall_valid", {31'b0, byte_valid}, 32'd1);
        check("stall_hold", {24'b0, byte_out}, {24'b0, exp});
        check("stall_no_done", {31'b0, block_done}, 32'd0);
        @(negedge clk);
      end
      byte_ready = 1'b1;
      check("byte_valid", {31'b0, byte_valid}, 32'd1);
      check("byte_value", {24'b0, byte_out}, {24'b0, exp});
      @(negedge clk);
    end
    byte_ready = 1'b0;
  endtask

  task automatic end_of_block(input int base);
    check("block_done_pulse", {31'b0, block_done}, 32'd1);
    check("valid_drop", {31'b0, byte_valid}, 32'd0);
    @(negedge clk);
    check("block_done_clear", {31'b0, block_done}, 32'd0);
    @(negedge clk);
    check("done_count", done_cnt - base, 32'd1);
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_valid", {31'b0, byte_valid}, 32'd0);
    check("rst_done", {31'b0, block_done}, 32'd0);
    check("rst_overrun", {31'b0, overrun}, 32'd0);
    check("rst_byte", {24'b0, byte_out}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Contiguous capture, back-to-back consumer
    done_base = done_cnt;
    byte_ready = 1'b1;
    send_block(128'h00112233445566778899AABBCCDDEEFF, 1'b0);
    drain(0, 16);
    end_of_block(done_base);
    check("no_overrun", {31'b0, overrun}, 32'd0);

    // Gapped input
    done_base = done_cnt;
    send_block(128'h00112233445566778899AABBCCDDEEFF, 1'b1);
    drain(0, 16);
    end_of_block(done_base);

    // Backpressure
    done_base = done_cnt;
    send_block(128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0, 1'b0);
    drain(5, 16);
    end_of_block(done_base);

    // Overrun during a stalled drain
    done_base = done_cnt;
    send_block(128'hDEADBEEF0123456789ABCDEFCAFEF00D, 1'b0);
    byte_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      valid_in  = 1'b1;
      cipher_in = j[0];
      @(negedge clk);
    end
    valid_in = 1'b0;
    check("overrun_set", {31'b0, overrun}, 32'd1);
    repeat (2) @(negedge clk);
    check("overrun_sticky", {31'b0, overrun}, 32'd1);
    drain(2, 16);
    end_of_block(done_base);
    check("overrun_after_drain", {31'b0, overrun}, 32'd1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("overrun_cleared", {31'b0, overrun}, 32'd0);

    // Clear mid-collect
    done_base = done_cnt;
    for (int i = 0; i < 70; i++) begin
      valid_in  = 1'b1;
      cipher_in = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    check("partial_busy", {31'b0, busy}, 32'd1);
    clear     = 1'b1;
    valid_in  = 1'b1;
    cipher_in = 1'b1;
    @(negedge clk);
    clear    = 1'b0;
    valid_in = 1'b0;
    check("clear_busy", {31'b0, busy}, 32'd0);
    check("clear_valid", {31'b0, byte_valid}, 32'd0);
    send_block(128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF00, 1'b0);
    drain(0, 16);
    end_of_block(done_base);

    // Asynchronous reset mid-drain
    done_base = done_cnt;
    send_block(128'h112233445566778899AABBCCDDEEFF00, 1'b0);
    drain(0, 4);
    #2 reset = 1'b0;
    #1;
    check("areset_valid", {31'b0, byte_valid}, 32'd0);
    check("areset_busy", {31'b0, busy}, 32'd0);
    check("areset_byte", {24'b0, byte_out}, 32'd0);
    #1 reset = 1'b1;
    sb.delete();
    @(negedge clk);
    check("areset_no_done", done_cnt - done_base, 32'd0);
    done_base = done_cnt;
    send_block(128'hA5A55A5A0102030405060708090A0B0C, 1'b0);
    drain(0, 16);
    end_of_block(done_base);
    check("final_overrun", {31'b0, overrun}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
